baud_tick_gen: RTL

- Runtime-programmable UART timing generator.
- Replaces the fixed compile-time divider with an integer-plus-fractional divisor and an oversampling tick chain.
- Produces oversample, bit-rate and mid-bit strobes plus a square-wave bit clock.
- Sits between the bus register file and the UART TX/RX engines. RX uses resync to align sampling to the start-bit edge.

---
 rtl/baud_tick_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/baud_tick_gen.sv
// Runtime-programmable UART timing generator: integer-plus-fractional
// divisor feeding an oversample tick chain, with oversample, bit-rate and
// mid-bit strobes, a square-wave bit clock and a sticky bad-load flag.
module baud_tick_gen #(
    parameter int DIV_W            = 16,
    parameter int FRAC_W           = 4,
    parameter int OSR              = 16,
    parameter int DEFAULT_DIV_INT  = 4,
    parameter int DEFAULT_DIV_FRAC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              resync,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              bclk,
    output logic              cfg_err
);

    localparam int OS_W  = $clog2(OSR);
    localparam int CNT_W = DIV_W + 1;

    // Reject configurations the tick chain cannot represent.
    if ((OSR & (OSR - 1)) != 0 || OSR < 4) begin : g_bad_osr
        $fatal(1, "baud_tick_gen: OSR must be a power of two and >= 4");
    end
    if (DEFAULT_DIV_INT < 2 ||
        longint'(DEFAULT_DIV_INT) >= (longint'(1) << DIV_W)) begin : g_bad_div
        $fatal(1, "baud_tick_gen: DEFAULT_DIV_INT must be >= 2 and fit DIV_W bits");
    end

    logic [DIV_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [FRAC_W-1:0] acc_q,      acc_d;
    logic              extra_q,    extra_d;
    logic [OS_W-1:0]   os_cnt_q,   os_cnt_d;
    logic              bclk_q,     bclk_d;
    logic              cfg_err_q,  cfg_err_d;

    logic [CNT_W-1:0]  period_m1;
    logic [FRAC_W:0]   acc_sum;
    logic [OS_W-1:0]   os_cnt_inc;
    logic              load_ok;
    logic              phase_clr;

    // Tick decode: the current period is act_int plus one cycle when the
    // fraction accumulator carried on the previous tick.
    always_comb begin
        period_m1 = {1'b0, act_int_q} + CNT_W'(extra_q) - CNT_W'(1);
        os_tick   = en & (cnt_q == period_m1);
        bit_tick  = os_tick & (os_cnt_q == OS_W'(OSR - 1));
        mid_tick  = os_tick & (os_cnt_q == OS_W'(OSR / 2 - 1));
    end

    assign bclk    = bclk_q;
    assign cfg_err = cfg_err_q;

    // A valid load clears the phase exactly like resync; an invalid load
    // masks a simultaneous resync so the phase is left untouched.
    assign load_ok   = div_load & (div_int >= DIV_W'(2));
    assign phase_clr = load_ok | (resync & ~div_load);

    // Next-state: divisor load / error flag, then phase clear, tick or count.
    always_comb begin
        // NOTE: every _d is defaulted to its _q first so no path through the
        // branches below can leave one unassigned and infer a latch.
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        extra_d    = extra_q;
        os_cnt_d   = os_cnt_q;
        bclk_d     = bclk_q;
        cfg_err_d  = cfg_err_q;
        acc_sum    = {1'b0, acc_q} + {1'b0, act_frac_q};
        os_cnt_inc = os_cnt_q + OS_W'(1);

        if (load_ok) begin
            act_int_d  = div_int;
            act_frac_d = div_frac;
            cfg_err_d  = 1'b0;
        end else if (div_load) begin
            cfg_err_d  = 1'b1;
        end

        if (phase_clr) begin
            cnt_d    = '0;
            acc_d    = '0;
            extra_d  = 1'b0;
            os_cnt_d = '0;
            bclk_d   = 1'b0;
        end else if (os_tick) begin
            cnt_d    = '0;
            acc_d    = acc_sum[FRAC_W-1:0];
            extra_d  = acc_sum[FRAC_W];
            os_cnt_d = os_cnt_inc;
            bclk_d   = os_cnt_inc[OS_W-1];
        end else if (en) begin
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            act_int_q  <= DIV_W'(DEFAULT_DIV_INT);
            act_frac_q <= FRAC_W'(DEFAULT_DIV_FRAC);
            cnt_q      <= '0;
            acc_q      <= '0;
            extra_q    <= 1'b0;
            os_cnt_q   <= '0;
            bclk_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            extra_q    <= extra_d;
            os_cnt_q   <= os_cnt_d;
            bclk_q     <= bclk_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule
